// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: parametrised AXI4-Lite slave register bank.
// RW/RO registers, byte-strobe writes, SLVERR out of range, write pulses.
module axi_lite_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_REGS = 16,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
    input  logic                                    s00_axi_aclk,
    input  logic                                    s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           s00_axi_awaddr,
    input  logic [2:0]                              s00_axi_awprot,
    input  logic                                    s00_axi_awvalid,
    output logic                                    s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         s00_axi_wstrb,
    input  logic                                    s00_axi_wvalid,
    output logic                                    s00_axi_wready,
    output logic [1:0]                              s00_axi_bresp,
    output logic                                    s00_axi_bvalid,
    input  logic                                    s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           s00_axi_araddr,
    input  logic [2:0]                              s00_axi_arprot,
    input  logic                                    s00_axi_arvalid,
    output logic                                    s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           s00_axi_rdata,
    output logic [1:0]                              s00_axi_rresp,
    output logic                                    s00_axi_rvalid,
    input  logic                                    s00_axi_rready,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [C_NUM_REGS-1:0]                   reg_wr_pulse
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int NB    = DW / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = AW - OFF;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [0:0]            w_state_q, w_state_d;
    logic [0:0]            r_state_q, r_state_d;
    logic                  aw_held_q, w_held_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DW-1:0]         w_data_q;
    logic [NB-1:0]         w_strb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DW-1:0]         rdata_q;
    logic [C_NUM_REGS-1:0] pulse_q;
    logic [DW-1:0]         regs_q [C_NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DW-1:0]         cur_data;
    logic [NB-1:0]         cur_strb;
    logic [C_NUM_REGS-1:0] wr_hit;
    logic                  rd_hit;
    logic [DW-1:0]         rd_val;
    logic                  unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[OFF-1:0], s00_axi_araddr[OFF-1:0]};

    assign s00_axi_bvalid  = (w_state_q == W_RESP);
    assign s00_axi_rvalid  = (r_state_q == R_DATA);
    assign s00_axi_awready = !aw_held_q && !s00_axi_bvalid;
    assign s00_axi_wready  = !w_held_q && !s00_axi_bvalid;
    assign s00_axi_arready = !s00_axi_rvalid;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign reg_wr_pulse    = pulse_q;

    assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
    assign w_hs   = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_idx   = aw_held_q ? aw_idx_q : s00_axi_awaddr[AW-1:OFF];
    assign cur_data = w_held_q ? w_data_q : s00_axi_wdata;
    assign cur_strb = w_held_q ? w_strb_q : s00_axi_wstrb;
    assign rd_idx   = s00_axi_araddr[AW-1:OFF];

    // One-hot decode of the write target; all zero when out of range
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_hit[i] = (32'(wr_idx) == 32'(i));
        end
    end

    // Read mux: RW register or live status slice, zero when out of range
    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (32'(rd_idx) == 32'(i)) begin
                rd_hit = 1'b1;
                rd_val = C_RO_MASK[i] ? ro_in[i*DW +: DW] : regs_q[i];
            end
        end
    end

    // Next-state logic for the write and read response FSMs
    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        unique case (w_state_q)
            W_IDLE:  if (commit) w_state_d = W_RESP;
            W_RESP:  if (s00_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        unique case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (s00_axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // FSM state, holding registers and response registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            pulse_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            pulse_q   <= commit ? wr_hit : '0;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= s00_axi_awaddr[AW-1:OFF];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= s00_axi_wdata;
                    w_strb_q <= s00_axi_wstrb;
                end
            end
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register array: byte-strobed update of the committed RW target
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_hit[i] && !C_RO_MASK[i]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (cur_strb[b]) begin
                            regs_q[i][8*b +: 8] <= cur_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign reg_out[g*DW +: DW] = C_RO_MASK[g] ? '0 : regs_q[g];
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: directed + randomized bench for axi_lite_regbank.
// 12 registers in a 16-slot map, register 1 read-only.
module tb_axi_lite_regbank;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 12;
    localparam logic [NR-1:0] RO = 12'h002;
    localparam int VW = NR * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [AW-1:0] araddr = '0;
    logic [2:0] awprot = '0;
    logic [2:0] arprot = '0;
    logic awvalid = 1'b0;
    logic wvalid = 1'b0;
    logic bready = 1'b0;
    logic arvalid = 1'b0;
    logic rready = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic [VW-1:0] ro_in = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;
    logic [VW-1:0] reg_out;
    logic [NR-1:0] reg_wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [NR];

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_NUM_REGS(NR),
        .C_RO_MASK(RO)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr),
        .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .ro_in(ro_in),
        .reg_out(reg_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] obs,
                         input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (!RO[i]) v[i*DW +: DW] = model[i];
        end
        return v;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a,
                                        input logic [DW-1:0] d,
                                        input logic [3:0] s,
                                        output logic [1:0] resp,
                                        output logic [NR-1:0] pulse);
        int idx;
        idx = int'(a) / 4;
        pulse = '0;
        resp = 2'b10;
        if (idx < NR) begin
            resp = 2'b00;
            pulse[idx] = 1'b1;
            if (!RO[idx]) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
    endfunction

    task automatic randomize_ro();
        for (int i = 0; i < NR; i++) ro_in[i*DW +: DW] = $urandom;
    endtask

    // mode 0: AW and W together; 1: AW first by gap; 2: W first by gap
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int mode,
                            input int gap, input int bdly);
        logic [1:0] eresp;
        logic [NR-1:0] epulse;
        bit aw_done, w_done, aw_fire, w_fire;
        int t;
        aw_done = 0;
        w_done = 0;
        t = 0;
        model_write(a, d, s, eresp, epulse);
        while (!(aw_done && w_done)) begin
            if (!aw_done && (mode != 2 || t >= gap)) begin
                awaddr = a;
                awvalid = 1'b1;
            end
            if (!w_done && (mode != 1 || t >= gap)) begin
                wdata = d;
                wstrb = s;
                wvalid = 1'b1;
            end
            if (aw_done) check("awready_while_held", awready, 0);
            if (w_done) check("wready_while_held", wready, 0);
            aw_fire = awvalid && awready;
            w_fire = wvalid && wready;
            @(negedge clk);
            t++;
            if (aw_fire) begin
                aw_done = 1;
                awvalid = 1'b0;
                awaddr = AW'($urandom);
            end
            if (w_fire) begin
                w_done = 1;
                wvalid = 1'b0;
                wdata = $urandom;
                wstrb = 4'($urandom);
            end
            if (t > 40) begin
                checks++;
                errors++;
                $error("FAIL write_timeout: observed no handshake expected handshake");
                awvalid = 1'b0;
                wvalid = 1'b0;
                break;
            end
        end
        check("bvalid_after_commit", bvalid, 1);
        check("bresp", bresp, eresp);
        check("wr_pulse", reg_wr_pulse, epulse);
        check("reg_out_after_write", reg_out, exp_vec());
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, eresp);
            check("wr_pulse_one_cycle", reg_wr_pulse, 0);
            check("aw_w_ready_blocked", {awready, wready}, 0);
            check("reg_out_hold", reg_out, exp_vec());
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        check("wr_pulse_clear", reg_wr_pulse, 0);
        check("aw_w_ready_back", {awready, wready}, 2'b11);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdly);
        logic [DW-1:0] ed;
        logic [1:0] er;
        int idx;
        idx = int'(a) / 4;
        if (idx < NR) begin
            ed = RO[idx] ? ro_in[idx*DW +: DW] : model[idx];
            er = 2'b00;
        end else begin
            ed = '0;
            er = 2'b10;
        end
        check("arready_idle", arready, 1);
        araddr = a;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        araddr = AW'($urandom);
        check("rvalid", rvalid, 1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        check("arready_busy", arready, 0);
        for (int i = 0; i < rdly; i++) begin
            randomize_ro();
            @(negedge clk);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, ed);
            check("rresp_hold", rresp, er);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        logic [DW-1:0] old;
        logic [1:0] eresp;
        logic [NR-1:0] epulse;
        logic [NR-1:0] pulses_seen;

        for (int i = 0; i < NR; i++) model[i] = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_resp", {bresp, rresp}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_reg_out", reg_out, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_readies", {awready, wready, arready}, 3'b111);

        // basic writes and readback, watching each pulse bit
        pulses_seen = '0;
        for (int i = 0; i < 4; i++) begin
            do_write(AW'(4 * i), DW'(i + 1), 4'hF, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) do_read(AW'(4 * i), 0);
        check("basic_reg0", reg_out[31:0], 32'h1);
        check("basic_reg3", reg_out[127:96], 32'h4);

        // byte strobes
        do_write(6'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_write(6'h08, 32'h11223344, 4'b0101, 1, 2, 1);
        do_read(6'h08, 1);
        check("strobe_value", reg_out[95:64], 32'hAA22CC44);

        // read-only register 1
        ro_in[1*DW +: DW] = 32'hDEADBEEF;
        do_write(6'h04, 32'h5, 4'hF, 0, 0, 0);
        check("ro_reg_out_zero", reg_out[63:32], 0);
        do_read(6'h05, 0);

        // out of range
        do_write(6'h30, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_read(6'h3C, 2);

        // W three cycles ahead of AW, B held off for five cycles
        do_write(6'h18, 32'hCAFEF00D, 4'hF, 2, 3, 5);
        do_read(6'h1A, 0);

        // same-cycle read and write of one register
        old = model[5];
        model_write(6'h14, 32'h5A5A0F0F, 4'hF, eresp, epulse);
        awaddr = 6'h14;
        awvalid = 1'b1;
        wdata = 32'h5A5A0F0F;
        wstrb = 4'hF;
        wvalid = 1'b1;
        araddr = 6'h14;
        arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        arvalid = 1'b0;
        check("rw_same_rdata_old", rdata, old);
        check("rw_same_valids", {bvalid, rvalid}, 2'b11);
        check("rw_same_reg_out", reg_out, exp_vec());
        check("rw_same_pulse", reg_wr_pulse, epulse);
        bready = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        rready = 1'b0;
        check("rw_same_done", {bvalid, rvalid}, 0);

        // randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(AW'($urandom_range(0, 63)), $urandom,
                         4'($urandom_range(0, 15)), $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                randomize_ro();
                do_read(AW'($urandom_range(0, 63)), $urandom_range(0, 3));
            end
        end

        // reset in the middle of outstanding responses
        awaddr = 6'h08;
        awvalid = 1'b1;
        wdata = 32'h12345678;
        wstrb = 4'hF;
        wvalid = 1'b1;
        araddr = 6'h00;
        arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        arvalid = 1'b0;
        check("pre_reset_valids", {bvalid, rvalid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valids", {bvalid, rvalid}, 0);
        check("async_rst_reg_out", reg_out, 0);
        check("async_rst_resp", {bresp, rresp}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        ro_in = '0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) do_read(AW'(4 * i), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
